line_steer_ctrl: RTL and testbench

Parametrised line-following steering controller. It succeeds the fixed six-sensor direction controller and generalises it to NPAIR left/right sensor pairs, with selectable sensor polarity, an explicit corner/turn state machine, and turn and stop timeouts. It sits between the raw reflectance sensor pins and the motor drive block, and produces the same 4-bit `dir` command codes the motor block already decodes. It also exports the debounced sensor vector for the LED status display.

---
 rtl/line_steer_ctrl.sv | 179 +++++++++++++++++
 tb/tb_line_steer_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/line_steer_ctrl.sv
// Line-following steering controller: synchronised, debounced NPAIR sensor pairs feeding a
// FOLLOW/CORNER/TURN/HALT FSM. Optional macro LINE_STEER_HARD_EN enables HARD_LEFT/HARD_RIGHT.
module line_steer_ctrl #(
    parameter int NPAIR         = 3,
    parameter int DEB_CYCLES    = 12_500_000,
    parameter int CORNER_CYCLES = 50_000_000,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2*NPAIR-1:0] sens,
    input  logic               direction,
    input  logic               run,
    output logic [3:0]         dir,
    output logic [2*NPAIR-1:0] stable_sens,
    output logic [1:0]         state
);
    localparam int DEB_W = $clog2(DEB_CYCLES) + 1;
    localparam int TMR_W = $clog2(CORNER_CYCLES) + 1;

    localparam logic [1:0] S_FOLLOW = 2'd0;
    localparam logic [1:0] S_CORNER = 2'd1;
    localparam logic [1:0] S_TURN   = 2'd2;
    localparam logic [1:0] S_HALT   = 2'd3;

    localparam logic [3:0] D_PROCEED      = 4'b0000;
    localparam logic [3:0] D_VEER_LEFT    = 4'b0101;
    localparam logic [3:0] D_VEER_RIGHT   = 4'b1001;
    localparam logic [3:0] D_NINETY_LEFT  = 4'b0111;
    localparam logic [3:0] D_NINETY_RIGHT = 4'b1011;
    localparam logic [3:0] D_STOP         = 4'b1111;
`ifdef LINE_STEER_HARD_EN
    localparam logic [3:0] D_HARD_LEFT    = 4'b0110;
    localparam logic [3:0] D_HARD_RIGHT   = 4'b1010;
`endif

    logic [2*NPAIR-1:0] line_raw;
    logic [2*NPAIR-1:0] sens_s1_reg, sens_s2_reg, line_prev_reg, stable_reg;
    logic [DEB_W-1:0]   deb_cnt_reg, deb_eff;
    logic               dsync1_reg, dsync2_reg, dprev_reg, dir_chg;
    logic [1:0]         state_reg, state_next;
    logic [TMR_W-1:0]   timer_reg, timer_next;
    logic               side_reg, side_next;
    logic [3:0]         dir_reg, dir_next;
    logic               lp_l, lp_r, sp_l, sp_r;

    // Polarity is normalised before synchronising so reset-cleared flops read as "no line".
    genvar gi;
    generate
        for (gi = 0; gi < 2*NPAIR; gi++) begin : g_pol
            assign line_raw[gi] = (ACTIVE_LOW != 0) ? ~sens[gi] : sens[gi];
        end
    endgenerate

    // A fresh change counts as the first cycle of its own persistence window.
    assign deb_eff = (sens_s2_reg != line_prev_reg) ? '0 : deb_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sens_s1_reg   <= '0;
            sens_s2_reg   <= '0;
            line_prev_reg <= '0;
            stable_reg    <= '0;
            deb_cnt_reg   <= '0;
            dsync1_reg    <= 1'b0;
            dsync2_reg    <= 1'b0;
            dprev_reg     <= 1'b0;
        end else begin
            sens_s1_reg   <= line_raw;
            sens_s2_reg   <= sens_s1_reg;
            line_prev_reg <= sens_s2_reg;
            dsync1_reg    <= direction;
            dsync2_reg    <= dsync1_reg;
            dprev_reg     <= dsync2_reg;
            if (sens_s2_reg == stable_reg) begin
                deb_cnt_reg <= '0;
            end else if (deb_eff == DEB_W'(DEB_CYCLES - 1)) begin
                stable_reg  <= sens_s2_reg;
                deb_cnt_reg <= '0;
            end else if (deb_eff != {DEB_W{1'b1}}) begin
                deb_cnt_reg <= deb_eff + DEB_W'(1);
            end else begin
                deb_cnt_reg <= deb_eff;
            end
        end
    end

    assign dir_chg = dsync2_reg ^ dprev_reg;

    // In reverse the rear pairs lead and the robot's left is the sensor's right.
    assign lp_l = dsync2_reg ? stable_reg[2*(NPAIR-1)]   : stable_reg[1];
    assign lp_r = dsync2_reg ? stable_reg[2*(NPAIR-1)+1] : stable_reg[0];
    assign sp_l = dsync2_reg ? stable_reg[2*(NPAIR-2)]   : stable_reg[3];
    assign sp_r = dsync2_reg ? stable_reg[2*(NPAIR-2)+1] : stable_reg[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_HALT;
            timer_reg <= '0;
            side_reg  <= 1'b0;
            dir_reg   <= D_STOP;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            side_reg  <= side_next;
            dir_reg   <= dir_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        side_next  = side_reg;
        if (!run) begin
            state_next = S_HALT;
        end else if (dir_chg) begin
            state_next = S_FOLLOW;
        end else begin
            case (state_reg)
                S_FOLLOW: if (!lp_l && !lp_r) state_next = S_CORNER;
                S_CORNER: begin
                    if (lp_l || lp_r) begin
                        state_next = S_FOLLOW;
                    end else if (sp_l ^ sp_r) begin
                        state_next = S_TURN;
                        side_next  = sp_r;
                    end else if (timer_reg == TMR_W'(CORNER_CYCLES - 1)) begin
                        state_next = S_HALT;
                    end
                end
                S_TURN: begin
                    if (lp_l && lp_r)
                        state_next = S_FOLLOW;
                    else if (timer_reg == TMR_W'(CORNER_CYCLES - 1))
                        state_next = S_HALT;
                end
                default: if (lp_l && lp_r) state_next = S_FOLLOW;
            endcase
        end
        if (state_next != state_reg)
            timer_next = '0;
        else if ((state_reg == S_CORNER || state_reg == S_TURN) && timer_reg != {TMR_W{1'b1}})
            timer_next = timer_reg + TMR_W'(1);
        else if (state_reg == S_CORNER || state_reg == S_TURN)
            timer_next = timer_reg;
        else
            timer_next = '0;
    end

    // Output follows the state being entered so dir and state always agree.
    always_comb begin
        dir_next = D_STOP;
        case (state_next)
            S_FOLLOW: begin
                if (lp_l && lp_r) begin
                    dir_next = D_PROCEED;
                end else if (lp_l) begin
                    dir_next = D_VEER_LEFT;
`ifdef LINE_STEER_HARD_EN
                    if (sp_l && !sp_r) dir_next = D_HARD_LEFT;
`endif
                end else if (lp_r) begin
                    dir_next = D_VEER_RIGHT;
`ifdef LINE_STEER_HARD_EN
                    if (sp_r && !sp_l) dir_next = D_HARD_RIGHT;
`endif
                end else begin
                    dir_next = D_PROCEED;
                end
            end
            S_CORNER: dir_next = D_PROCEED;
            S_TURN:   dir_next = side_next ? D_NINETY_RIGHT : D_NINETY_LEFT;
            default:  dir_next = D_STOP;
        endcase
    end

    assign dir         = dir_reg;
    assign state       = state_reg;
    assign stable_sens = stable_reg;
endmodule

// File: tb/tb_line_steer_ctrl.sv
// Scoreboard bench for line_steer_ctrl: each stimulus pushes timed expectations which a
// negedge monitor pops and compares against dir/state/stable_sens.
module tb_line_steer_ctrl;
    localparam logic [3:0] PROCEED = 4'b0000, VL = 4'b0101, VR = 4'b1001;
    localparam logic [3:0] NL = 4'b0111, NR = 4'b1011, STOP = 4'b1111;
`ifdef LINE_STEER_HARD_EN
    localparam logic [3:0] HL = 4'b0110, HR = 4'b1010;
`else
    localparam logic [3:0] HL = 4'b0101, HR = 4'b1001;
`endif
    localparam logic [1:0] FOL = 2'd0, COR = 2'd1, TRN = 2'd2, HLT = 2'd3;

    logic       clk = 1'b0;
    logic       rst, direction, run;
    logic [5:0] sens, stable_sens;
    logic [3:0] dir;
    logic [1:0] state;

    always #5 clk = ~clk;

    line_steer_ctrl #(
        .NPAIR(3), .DEB_CYCLES(4), .CORNER_CYCLES(16), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .sens(sens), .direction(direction), .run(run),
        .dir(dir), .stable_sens(stable_sens), .state(state)
    );

    typedef struct {
        int         cyc;
        logic [3:0] d;
        logic [1:0] s;
        logic [5:0] b;
        bit         cb;
    } exp_t;

    exp_t  sb[$];
    string tags[$];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic exp_at(input int d, input string tag, input logic [3:0] ed,
                          input logic [1:0] es, input logic [5:0] eb, input bit cb);
        exp_t e;
        e.cyc = cyc + d;
        e.d   = ed;
        e.s   = es;
        e.b   = eb;
        e.cb  = cb;
        sb.push_back(e);
        tags.push_back(tag);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : mon
        exp_t  e;
        string t;
        while (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            t = tags.pop_front();
            $display("txn %-10s cyc=%0d dir=%b state=%0d stable=%b", t, cyc, dir, state, stable_sens);
            check_val({t, ".dir"}, {4'h0, dir}, {4'h0, e.d});
            check_val({t, ".state"}, {6'h0, state}, {6'h0, e.s});
            if (e.cb) check_val({t, ".stable"}, {2'b0, stable_sens}, {2'b0, e.b});
        end
    end

    logic [5:0] fwd_s [5] = '{6'b101011, 6'b011110, 6'b011011, 6'b010111, 6'b100111};
    logic [3:0] fwd_d [5] = '{HL, VR, VR, HR, VL};
    logic [5:0] rev_s [4] = '{6'b111110, 6'b111101, 6'b110101, 6'b111010};
    logic [3:0] rev_d [4] = '{VR, VL, HL, HR};

    initial begin
        logic [3:0] prev;
        rst = 1'b1; sens = 6'b111111; direction = 1'b0; run = 1'b1;
        tick(3);
        exp_at(0, "reset", STOP, HLT, 6'b0, 1);
        rst = 1'b0;
        exp_at(1, "idle1", STOP, HLT, 6'b0, 1);
        exp_at(12, "idle12", STOP, HLT, 6'b0, 1);
        exp_at(30, "idle30", STOP, HLT, 6'b0, 1);
        tick(30);

        // Forward with no line: FOLLOW, CORNER, then timeout to HALT.
        direction = 1'b1;
        exp_at(3, "dchg", PROCEED, FOL, 6'b0, 1);
        exp_at(4, "corner", PROCEED, COR, 6'b0, 0);
        exp_at(19, "cor_last", PROCEED, COR, 6'b0, 0);
        exp_at(20, "cor_to", STOP, HLT, 6'b0, 0);
        tick(22);

        sens = 6'b001111;
        exp_at(5, "deb_pre", STOP, HLT, 6'b0, 1);
        exp_at(6, "deb_load", STOP, HLT, 6'b110000, 1);
        exp_at(7, "follow", PROCEED, FOL, 6'b110000, 1);
        tick(10);

        sens = 6'b011111;
        for (int k = 1; k < 10; k += 2) exp_at(k, "glitch", PROCEED, FOL, 6'b110000, 1);
        tick(3);
        sens = 6'b001111;
        tick(7);

        // Corner then left turn, recovered by the lead pair.
        sens = 6'b111011;
        exp_at(6, "c_stab", PROCEED, FOL, 6'b000100, 1);
        exp_at(7, "c_corner", PROCEED, COR, 6'b000100, 1);
        exp_at(8, "c_turn", NL, TRN, 6'b000100, 1);
        tick(10);
        sens = 6'b001111;
        exp_at(6, "t_hold", NL, TRN, 6'b110000, 1);
        exp_at(7, "t_exit", PROCEED, FOL, 6'b110000, 1);
        tick(10);

        // Turn that times out.
        sens = 6'b111011;
        exp_at(8, "to_turn", NL, TRN, 6'b000100, 1);
        exp_at(23, "to_last", NL, TRN, 6'b000100, 0);
        exp_at(24, "turn_to", STOP, HLT, 6'b000100, 1);
        tick(26);
        sens = 6'b001111;
        exp_at(7, "to_rec", PROCEED, FOL, 6'b110000, 1);
        tick(10);

        // Second pair both on line is not a turn cue.
        sens = 6'b110011;
        exp_at(7, "sb_corner", PROCEED, COR, 6'b001100, 1);
        exp_at(22, "sb_last", PROCEED, COR, 6'b001100, 0);
        exp_at(23, "sb_to", STOP, HLT, 6'b001100, 0);
        tick(25);
        sens = 6'b001111;
        exp_at(7, "sb_rec", PROCEED, FOL, 6'b110000, 1);
        tick(10);

        prev = PROCEED;
        for (int i = 0; i < 5; i++) begin
            sens = fwd_s[i];
            exp_at(6, "fwd_hold", prev, FOL, ~fwd_s[i], 1);
            exp_at(7, "fwd_tab", fwd_d[i], FOL, ~fwd_s[i], 1);
            prev = fwd_d[i];
            tick(10);
        end

        sens = 6'b001111;
        exp_at(7, "pre_run", PROCEED, FOL, 6'b110000, 1);
        tick(10);
        run = 1'b0;
        exp_at(1, "run0", STOP, HLT, 6'b110000, 1);
        exp_at(2, "run0b", STOP, HLT, 6'b110000, 0);
        tick(2);
        run = 1'b1;
        exp_at(1, "run1", PROCEED, FOL, 6'b110000, 0);
        tick(3);

        // Reverse: rear pair leads, sides swapped.
        direction = 1'b0;
        sens = 6'b111100;
        exp_at(3, "r_dchg", PROCEED, FOL, 6'b110000, 1);
        exp_at(4, "r_corner", PROCEED, COR, 6'b110000, 0);
        exp_at(6, "r_stab", PROCEED, COR, 6'b000011, 1);
        exp_at(7, "r_follow", PROCEED, FOL, 6'b000011, 1);
        tick(10);
        for (int i = 0; i < 4; i++) begin
            sens = rev_s[i];
            exp_at(7, "rev_tab", rev_d[i], FOL, ~rev_s[i], 1);
            tick(10);
        end

        // Reverse right turn, abandoned by reset.
        sens = 6'b111011;
        exp_at(7, "rt_corner", PROCEED, COR, 6'b000100, 1);
        exp_at(8, "rt_turn", NR, TRN, 6'b000100, 1);
        tick(10);
        rst = 1'b1;
        exp_at(1, "rst_turn", STOP, HLT, 6'b0, 1);
        tick(2);
        rst = 1'b0;
        exp_at(1, "post_rst", STOP, HLT, 6'b0, 1);
        exp_at(8, "post_rst8", STOP, HLT, 6'b000100, 1);
        tick(12);

        for (int k = 0; k < 50 && sb.size() > 0; k++) @(posedge clk);
        check_val("sb_drain", 8'(sb.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule
